// File: rtl/lc3_memaccess_seq_pkg.sv
// Shared types and encodings for the LC3 memory-access sequencer.
package memaccess_seq_pkg;

  typedef enum logic [2:0] {S_IDLE, S_IND, S_RD, S_WR, S_FIN} state_t;

  localparam logic [1:0] MS_IND  = 2'd0;
  localparam logic [1:0] MS_RD   = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  function automatic logic [1:0] ms_of(input state_t s);
    case (s)
      S_IND:   return MS_IND;
      S_RD:    return MS_RD;
      S_WR:    return MS_WR;
      default: return MS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lc3_memaccess_seq_if.sv
// Request/response bundle between execute, the sequencer and MemAccess.
interface lc3_memaccess_seq_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              start;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] st_data;
  logic              stall;
  logic [DATA_W-1:0] dmem_dout;
  logic [1:0]        mem_state;
  logic              m_control;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] ind_addr;
  logic [DATA_W-1:0] load_data;
  logic              busy;
  logic              done;

  // ind_addr is what MemAccess selects when m_control is high.
  modport master (
    input  start, opcode, ea, st_data, stall, dmem_dout,
    output mem_state, m_control, m_addr, m_data, ind_addr, load_data, busy, done
  );

  modport slave (
    output start, opcode, ea, st_data, stall, dmem_dout,
    input  mem_state, m_control, m_addr, m_data, ind_addr, load_data, busy, done
  );
endinterface

// File: rtl/lc3_memaccess_seq_op_decode.sv
// Classifies an LC3 opcode into memory / store / indirect access kinds.
module memaccess_op_decode
  import memaccess_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_indirect
);

  always_comb begin
    is_mem      = 1'b1;
    is_store    = 1'b0;
    is_indirect = 1'b0;
    case (opcode)
      OP_LD, OP_LDR: ;
      OP_ST, OP_STR: is_store = 1'b1;
      OP_LDI:        is_indirect = 1'b1;
      OP_STI: begin
        is_store    = 1'b1;
        is_indirect = 1'b1;
      end
      default:       is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/lc3_memaccess_seq.sv
// LC3 memory-access sequencer: walks IND/RD/WR phases for one memory
// instruction and drives registered controls toward MemAccess.
module lc3_memaccess_seq
  import memaccess_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic               clock,
  input logic               reset,
  lc3_memaccess_seq_if.master bus
);

  state_t state, state_nx;
  logic   is_mem, is_store, is_indirect;
  logic   lat_store, ind_flag;

  logic [1:0] ms_nx;
  logic       mctl_nx, busy_nx, done_nx;

  logic [1:0]        mem_state_r;
  logic              m_control_r, busy_r, done_r;
  logic [ADDR_W-1:0] m_addr_r, ind_addr_r;
  logic [DATA_W-1:0] m_data_r, load_data_r;

  memaccess_op_decode u_dec (
    .opcode      (bus.opcode),
    .is_mem      (is_mem),
    .is_store    (is_store),
    .is_indirect (is_indirect)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          state <= S_IDLE;
    else if (!bus.stall) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) begin
        if (!is_mem)          state_nx = S_FIN;
        else if (is_indirect) state_nx = S_IND;
        else if (is_store)    state_nx = S_WR;
        else                  state_nx = S_RD;
      end
      S_IND:        state_nx = lat_store ? S_WR : S_RD;
      S_RD, S_WR:   state_nx = S_FIN;
      S_FIN:        state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    ms_nx   = ms_of(state_nx);
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_FIN);
    mctl_nx = (state_nx == S_RD || state_nx == S_WR) && (ind_flag || state == S_IND);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_state_r <= MS_IDLE;
      m_control_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      m_addr_r    <= '0;
      m_data_r    <= '0;
      ind_addr_r  <= '0;
      load_data_r <= '0;
      lat_store   <= 1'b0;
      ind_flag    <= 1'b0;
    end else if (!bus.stall) begin
      mem_state_r <= ms_nx;
      m_control_r <= mctl_nx;
      busy_r      <= busy_nx;
      done_r      <= done_nx;
      if (state == S_IDLE && bus.start) begin
        m_addr_r  <= bus.ea;
        m_data_r  <= bus.st_data;
        lat_store <= is_store;
      end
      if (state == S_IND) begin
        ind_addr_r <= ADDR_W'(bus.dmem_dout);
        ind_flag   <= 1'b1;
      end else if (state == S_FIN) begin
        ind_flag   <= 1'b0;
      end
      if (state == S_RD) load_data_r <= bus.dmem_dout;
    end
  end

  assign bus.mem_state = mem_state_r;
  assign bus.m_control = m_control_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_data    = m_data_r;
  assign bus.ind_addr  = ind_addr_r;
  assign bus.load_data = load_data_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_lc3_memaccess_seq.sv
// Scoreboard bench for lc3_memaccess_seq against a transaction-level memory model.
module tb_lc3_memaccess_seq;
  import memaccess_seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  lc3_memaccess_seq_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_memaccess_seq #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Data memory seen by the DUT, and the reference image kept by the model.
  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];

  assign bus.dmem_dout = mem[bus.m_control ? bus.ind_addr : bus.m_addr];

  always @(posedge clock)
    if (!reset && bus.mem_state == MS_WR)
      mem[bus.m_control ? bus.ind_addr : bus.m_addr] <= bus.m_data;

  typedef struct {
    int          done_edge;
    int          done_len;
    logic [15:0] tr;
    int          tlen;
    logic [15:0] ea, st, ld, waddr, iaddr;
    bit          ind;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_ld = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: collects the phase trace and scores each completion.
  logic [15:0] tr;
  int          tr_len   = 0;
  bit          in_done  = 0;
  bit          have_cur = 0;
  int          dlen     = 0;
  exp_t        cur, e;

  always @(negedge clock) begin
    if (reset) begin
      tr = '0; tr_len = 0; in_done = 0; have_cur = 0;
    end else begin
      if (bus.mem_state != MS_IDLE) begin
        if (tr_len < 8) tr[2*tr_len +: 2] = bus.mem_state;
        tr_len++;
        if (q.size() == 0) chk("phase_txn_pending", 32'(q.size()), 1);
        else begin
          e = q[0];
          if (bus.mem_state == MS_IND) begin
            chk("ind_m_addr", bus.m_addr, e.ea);
            chk("ind_m_control", bus.m_control, 0);
          end else begin
            chk("phase_m_control", bus.m_control, e.ind);
            if (!e.ind) chk("phase_m_addr", bus.m_addr, e.ea);
            if (bus.mem_state == MS_WR) begin
              chk("wr_m_data", bus.m_data, e.st);
              chk("wr_eff_addr", bus.m_control ? bus.ind_addr : bus.m_addr, e.waddr);
            end
          end
        end
      end
      if (bus.done && !in_done) begin
        in_done = 1; dlen = 1;
        if (q.size() == 0) begin
          chk("spurious_done", 32'(q.size()), 1);
          have_cur = 0;
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          chk("done_cycle", cyc, cur.done_edge);
          chk("phase_trace_len", tr_len, cur.tlen);
          chk("phase_trace", tr, cur.tr);
          chk("load_data", bus.load_data, cur.ld);
          chk("busy_in_done", bus.busy, 1);
          if (cur.ind) chk("ind_addr", bus.ind_addr, cur.iaddr);
        end
        tr = '0; tr_len = 0;
      end else if (bus.done) begin
        dlen++;
      end else if (in_done) begin
        in_done = 0;
        if (have_cur) chk("done_length", dlen, cur.done_len);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d,
                       input int k, input bit spur, input int off);
    exp_t        it;
    bit          load, store, ind;
    int          lat, n, o;
    logic [15:0] ptr, tgt;
    load  = op inside {OP_LD, OP_LDR, OP_LDI};
    store = op inside {OP_ST, OP_STR, OP_STI};
    ind   = op inside {OP_LDI, OP_STI};
    ptr   = ref_mem[a];
    tgt   = ind ? ptr : a;
    lat   = ind ? 3 : (load || store) ? 2 : 1;
    it.tr = '0; n = 0;
    if (ind) for (int i = 0; i <= k; i++) begin it.tr[2*n +: 2] = MS_IND; n++; end
    if (load || store)
      for (int i = 0; i <= (ind ? 0 : k); i++) begin
        it.tr[2*n +: 2] = load ? MS_RD : MS_WR; n++;
      end
    it.tlen = n;
    if (load)  exp_ld = ref_mem[tgt];
    if (store) ref_mem[tgt] = d;
    it.ld = exp_ld; it.ea = a; it.st = d; it.waddr = tgt; it.iaddr = ptr; it.ind = ind;
    it.done_edge = cyc + lat + ((load || store) ? k : 0);
    it.done_len  = (load || store) ? 1 : 1 + k;
    q.push_back(it);
    bus.start = 1; bus.opcode = op; bus.ea = a; bus.st_data = d;
    @(posedge clock); #1;
    bus.start = 0;
    o = off % (lat + k);
    for (int c = 0; c < lat + k; c++) begin
      bus.stall = (c < k);
      bus.start = spur && (c == o);
      if (bus.start) begin
        bus.opcode = OP_LD; bus.ea = 16'($urandom); bus.st_data = 16'($urandom);
      end
      @(posedge clock); #1;
    end
    bus.stall = 0; bus.start = 0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask

  logic [3:0] ops [10] = '{OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI,
                           4'b0001, 4'b0101, 4'b1100, 4'b0000};

  initial begin
    int          k, bad;
    logic [15:0] v;
    bus.start = 0; bus.stall = 0; bus.opcode = 0; bus.ea = 0; bus.st_data = 0;
    for (int i = 0; i < 65536; i++) begin mem[i] <= 16'h0; ref_mem[i] = 16'h0; end
    for (int i = 16'h3000; i < 16'h3100; i++) begin
      v = 16'h3000 + 16'($urandom_range(0, 255));
      preload(16'(i), v);
    end
    preload(16'h3010, 16'hBEEF);
    preload(16'h3000, 16'h4000);
    preload(16'h3020, 16'h3030);
    preload(16'h3030, 16'h5A5A);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_state", bus.mem_state, MS_IDLE);
    chk("rst_m_control", bus.m_control, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_load_data", bus.load_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 0;
    @(posedge clock); #1;

    issue(OP_LD,   16'h3010, 16'h0000, 0, 0, 0);
    issue(OP_STI,  16'h3000, 16'h1234, 0, 0, 0);
    issue(OP_LDI,  16'h3020, 16'h0000, 3, 0, 0);
    issue(4'b0001, 16'h3011, 16'h7777, 0, 0, 0);
    issue(OP_LDR,  16'h3012, 16'h0000, 0, 1, 0);
    issue(OP_ST,   16'h3013, 16'hC0DE, 0, 1, 1);
    issue(4'b0101, 16'h3014, 16'h0000, 2, 0, 0);

    // start together with stall in IDLE must not be taken
    bus.start = 1; bus.stall = 1; bus.opcode = OP_LD; bus.ea = 16'h3015;
    @(posedge clock); #1;
    bus.start = 0; bus.stall = 0;
    @(posedge clock); #1;
    chk("stall_start_busy", bus.busy, 0);
    chk("stall_start_state", bus.mem_state, MS_IDLE);

    // reset during WR abandons the store
    bus.start = 1; bus.opcode = OP_ST; bus.ea = 16'h3050; bus.st_data = 16'hAAAA;
    @(posedge clock); #1;
    bus.start = 0;
    chk("pre_reset_wr", bus.mem_state, MS_WR);
    #1 reset = 1;
    #1;
    chk("async_rst_mem_state", bus.mem_state, MS_IDLE);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_load_data", bus.load_data, 0);
    @(posedge clock); #1;
    reset = 0;
    exp_ld = 16'h0;
    repeat (6) @(posedge clock);
    #1;
    chk("abandoned_store", mem[16'h3050], ref_mem[16'h3050]);
    issue(OP_LD, 16'h3010, 16'h0000, 0, 0, 0);

    repeat (60) begin
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(ops[$urandom_range(0, 9)], 16'h3000 + 16'($urandom_range(0, 255)),
            16'($urandom), k, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    repeat (5) @(posedge clock);
    #1;
    chk("pending_txns", 32'(q.size()), 0);
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_memaccess_seq.md
# lc3_memaccess_seq

Memory-access sequencer for the LC3 pipeline: the initiator side of the memaccess_in bus. Takes a memory-class instruction from execute, steps mem_state through indirect/read/write phases, drives m_control, m_addr and m_data toward the MemAccess stage, and captures dmem_dout for loads. Sits between the controller/execute stage and MemAccess; the memaccess_in UVMF agent monitors its outputs.

## Interface
Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle request pulse; accepted only in IDLE.
- opcode  input  4  LC3 IR[15:12], sampled with start.
- ea  input  ADDR_W  effective address from execute, sampled with start.
- st_data  input  DATA_W  store data, sampled with start.
- stall  input  1  freezes the FSM and all registers while high.
- dmem_dout  input  DATA_W  data-memory read data; asynchronous read, valid in the same cycle as the address.
- mem_state  output  2  0 indirect read, 1 read, 2 write, 3 idle.
- m_control  output  1  0 selects m_addr; 1 selects the captured indirect address.
- m_addr  output  ADDR_W  direct address.
- m_data  output  DATA_W  store data.
- load_data  output  DATA_W  last captured load value.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, IND, RD, WR, FIN.
- In IDLE, mem_state=3 and m_control=0.
- The start edge in IDLE latches opcode, ea and st_data. Next state by opcode:
  - LD 0010, LDR 0110: RD.
  - ST 0011, STR 0111: WR.
  - LDI 1010, STI 1011: IND.
  - Any other opcode: FIN. No memory phase is entered; mem_state stays 3.
- IND:
  - mem_state=0, m_addr=ea, m_control=0.
  - At the end of the cycle, dmem_dout is registered into ind_addr.
  - Next state is RD for LDI, WR for STI. The indirect flag is set.
- RD:
  - mem_state=1, m_control=indirect flag.
  - load_data is updated with dmem_dout at the end of the cycle.
  - Next state is FIN.
- WR:
  - mem_state=2, m_data=st_data, m_control=indirect flag.
  - Next state is FIN.
- FIN:
  - done=1 for this cycle, mem_state=3, indirect flag cleared.
  - Next state is IDLE.
- start while busy=1 is ignored and is not queued.
- stall=1 holds the state and every register, including done. A stalled FIN extends the done pulse for the stall duration.
- Reset values of all outputs: mem_state=3, m_control=0, m_addr=0, m_data=0, load_data=0, busy=0, done=0. ind_addr and the indirect flag also reset to 0.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Start sampled at edge N. Unstalled latencies:
  - LD/ST: phase in cycle N+1, done in cycle N+2.
  - LDI/STI: IND in N+1, RD/WR in N+2, done in N+3.
  - Non-memory opcode: done in N+1.
- The earliest next start is in the done cycle. It is accepted at the edge that returns the FSM to IDLE only if the FSM is already in IDLE; otherwise that start is dropped. Minimum start spacing: opcode latency + 1 cycles.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately, asynchronously.
  - The in-flight access is abandoned, and no done is issued for it.
  - After reset release, operation resumes at the first clock edge.
- start and stall high together in IDLE: stall wins and start is not accepted.

## Structure
- Shared package memaccess_seq_pkg holds:
  - typedef enum for the FSM states.
  - mem_state encodings MS_IND=0, MS_RD=1, MS_WR=2, MS_IDLE=3.
  - opcode constants OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI.
- One sub-module, memaccess_op_decode: combinational opcode to {is_mem, is_store, is_indirect}.

## Test plan
- LD: opcode=0010, ea=0x3010, dmem_dout=0xBEEF → mem_state 1 for one cycle, m_addr=0x3010, m_control=0; done next cycle; load_data=0xBEEF.
- STI: opcode=1011, ea=0x3000, st_data=0x1234, dmem_dout=0x4000 in IND → mem_state sequence 0,2,3; m_control=0 then 1; m_data=0x1234; done in N+3.
- LDI with stall: stall raised for 3 cycles in IND → mem_state held at 0 for 4 cycles; ind_addr captured once; done one cycle after RD.
- Non-memory ADD opcode=0001 → mem_state stays 3; done in N+1; load_data unchanged.
- start pulsed during RD of a prior LDR → ignored; exactly one done.
- Reset asserted in WR → mem_state=3, busy=0, done=0 immediately; no done after release; next LD completes normally.
